spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 216 +++++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_reader
// Brief    : SPI mode-0 master that reads the JEDEC ID (0x9F) or a data block
//            from a serial flash and returns it as a ready/valid byte stream.
//            Define SPI_FLASH_READER_FAST_READ_EN for 0x0B fast read + 8 dummy clocks.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_reader #(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_BYTES = 3,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic                    i_mode,
    input  logic [8*ADDR_BYTES-1:0] i_addr,
    input  logic [LEN_W-1:0]        i_len,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [7:0]              o_tdata,
    output logic                    o_tlast,
    output logic                    spi_ss,
    output logic                    spi_sck,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] c_READ_OP   = 8'h0B;
    localparam logic       c_FAST_READ = 1'b1;
`else
    localparam logic [7:0] c_READ_OP   = 8'h03;
    localparam logic       c_FAST_READ = 1'b0;
`endif
    localparam logic [7:0] c_ID_OP     = 8'h9F;
    localparam int         c_AW        = 8 * ADDR_BYTES;
    localparam logic [8:0] c_DIV_END   = 9'(CLK_DIV - 1);
    localparam logic [8:0] c_FIN_END   = 9'(2 * CLK_DIV - 1);
    localparam logic [2:0] c_ABYTE_END = 3'(ADDR_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        HOLD  = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [8:0]        r_cnt;
    logic              r_sck;
    logic              r_ss;
    logic [2:0]        r_bit;
    logic [7:0]        r_tx;
    logic [7:0]        r_rx;
    logic [c_AW-1:0]   r_addr;
    logic [2:0]        r_abyte;
    logic              r_mode;
    logic [LEN_W-1:0]  r_remain;
    logic              r_tvalid;
    logic [7:0]        r_tdata;
    logic              r_tlast;
    logic              r_done;

    logic              w_accept;
    logic              w_zero_len;
    logic              w_shifting;
    logic              w_div_end;
    logic              w_stall;
    logic              w_rise;
    logic              w_fall;
    logic              w_byte_end;
    logic              w_last;
    logic              w_load;
    logic              w_tx_reload;
    logic              w_fin_end;

    assign w_accept   = (r_state == IDLE) && i_start && (i_len != '0);
    assign w_zero_len = (r_state == IDLE) && i_start && (i_len == '0);
    assign w_shifting = (r_state == CMD) || (r_state == ADDR) ||
                        (r_state == DUMMY) || (r_state == DATA);
    assign w_div_end  = (r_cnt == c_DIV_END);
    // A data byte may only start clocking once the output register has room.
    assign w_stall    = (r_state == DATA) && !r_sck && (r_bit == 3'd0) &&
                        r_tvalid && !o_tready;
    assign w_rise     = w_shifting && !r_sck && w_div_end && !w_stall;
    assign w_fall     = w_shifting && r_sck && w_div_end;
    assign w_byte_end = w_fall && (r_bit == 3'd7);
    assign w_last     = (r_remain == LEN_W'(1));
    assign w_load     = w_byte_end && (r_state == DATA);
    assign w_tx_reload = w_byte_end &&
                         (((r_state == CMD) && r_mode) ||
                          ((r_state == ADDR) && (r_abyte != c_ABYTE_END)));
    assign w_fin_end  = (r_state == FIN) && (r_cnt == c_FIN_END) &&
                        (!r_tvalid || o_tready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = CMD;
            CMD:     if (w_byte_end) w_state_nxt = r_mode ? ADDR : DATA;
            ADDR:    if (w_byte_end && (r_abyte == c_ABYTE_END))
                         w_state_nxt = c_FAST_READ ? DUMMY : DATA;
            DUMMY:   if (w_byte_end) w_state_nxt = DATA;
            DATA:    if (w_byte_end && w_last) w_state_nxt = HOLD;
            HOLD:    if (w_div_end) w_state_nxt = FIN;
            FIN:     if (w_fin_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_sck    <= 1'b0;
            r_ss     <= 1'b1;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_addr   <= '0;
            r_abyte  <= '0;
            r_mode   <= 1'b0;
            r_remain <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_zero_len || w_fin_end;
            if (w_accept) begin
                r_mode   <= i_mode;
                r_addr   <= i_addr;
                r_remain <= i_len;
                r_abyte  <= '0;
                r_ss     <= 1'b0;
                r_sck    <= 1'b0;
                r_bit    <= '0;
                r_cnt    <= '0;
                r_tx     <= i_mode ? c_READ_OP : c_ID_OP;
            end else if (w_shifting) begin
                if (!w_stall) begin
                    r_cnt <= w_div_end ? 9'd0 : r_cnt + 9'd1;
                end
                if (w_rise) begin
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[6:0], spi_miso};
                end
                if (w_fall) begin
                    r_sck <= 1'b0;
                    r_bit <= r_bit + 3'd1;
                    if (w_tx_reload) begin
                        r_tx   <= r_addr[c_AW-1 -: 8];
                        r_addr <= r_addr << 8;
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                    end
                    if (w_byte_end && (r_state == ADDR)) begin
                        r_abyte <= r_abyte + 3'd1;
                    end
                    if (w_load) begin
                        r_remain <= r_remain - LEN_W'(1);
                    end
                end
            end else if (r_state == HOLD) begin
                r_cnt <= w_div_end ? 9'd0 : r_cnt + 9'd1;
                if (w_div_end) begin
                    r_ss <= 1'b1;
                end
            end else if (r_state == FIN) begin
                if (r_cnt != c_FIN_END) begin
                    r_cnt <= r_cnt + 9'd1;
                end
            end
        end
    end

    // One-byte output register; only loaded when empty, so contents hold under back-pressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= r_rx;
            r_tlast  <= w_last;
        end else if (r_tvalid && o_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end
    end

    assign o_busy   = (r_state != IDLE);
    assign o_done   = r_done;
    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;
    assign o_tlast  = r_tlast;
    assign spi_ss   = r_ss;
    assign spi_sck  = r_sck;
    assign spi_mosi = ((r_state == CMD) || (r_state == ADDR)) ? r_tx[7] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_reader
// Brief    : Directed self-checking bench for spi_flash_reader with a small
//            behavioural serial-flash model (ID EF 40 18, data = addr[7:0]^A5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;

    localparam int CLK_DIV    = 2;
    localparam int ADDR_BYTES = 3;
    localparam int LEN_W      = 16;
    localparam int CLK_PERIOD = 10;
`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] c_RD_OP = 8'h0B;
`else
    localparam logic [7:0] c_RD_OP = 8'h03;
`endif

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        i_start  = 1'b0;
    logic        i_mode   = 1'b0;
    logic [23:0] i_addr   = '0;
    logic [15:0] i_len    = '0;
    logic        tready   = 1'b1;
    logic        spi_miso = 1'b0;
    logic        o_busy, o_done, o_tvalid, o_tlast;
    logic [7:0]  o_tdata;
    logic        spi_ss, spi_sck, spi_mosi;

    spi_flash_reader #(
        .CLK_DIV    (CLK_DIV),
        .ADDR_BYTES (ADDR_BYTES),
        .LEN_W      (LEN_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_start  (i_start),
        .i_mode   (i_mode),
        .i_addr   (i_addr),
        .i_len    (i_len),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_tvalid (o_tvalid),
        .o_tready (tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .spi_ss   (spi_ss),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #(CLK_PERIOD/2) clk = ~clk;

    // ---------------- flash model ----------------
    int          m_bits;
    logic [7:0]  m_op;
    logic [23:0] m_addr;
    logic [7:0]  m_sh;
    logic [7:0]  m_log [16];
    int          m_nlog;
    int          ss_falls;
    int          sck_rises;
    int          first_gap;
    time         t_fall;

    function automatic logic model_bit(input int p, input logic [7:0] op, input logic [23:0] a);
        logic [7:0]  b;
        logic [23:0] da;
        int          dstart;
        b      = 8'h00;
        dstart = (op == 8'h0B) ? 40 : 32;
        if (op == 8'h9F && p >= 8) begin
            case ((p - 8) / 8)
                0:       b = 8'hEF;
                1:       b = 8'h40;
                2:       b = 8'h18;
                default: b = 8'h00;
            endcase
        end else if ((op == 8'h03 || op == 8'h0B) && p >= dstart) begin
            da = a + 24'((p - dstart) / 8);
            b  = da[7:0] ^ 8'hA5;
        end
        return b[7 - (p % 8)];
    endfunction

    always @(negedge spi_ss or posedge spi_sck) begin
        if (!spi_sck) begin
            m_bits   <= 0;
            m_op     <= '0;
            m_addr   <= '0;
            m_nlog   <= 0;
            ss_falls <= ss_falls + 1;
            t_fall   <= $time;
        end else begin
            if (m_bits == 0) first_gap <= int'(($time - t_fall) / CLK_PERIOD);
            if (m_bits < 8) m_op <= {m_op[6:0], spi_mosi};
            else if (m_bits < 32) m_addr <= {m_addr[22:0], spi_mosi};
            m_sh <= {m_sh[6:0], spi_mosi};
            if ((m_bits % 8) == 7 && m_nlog < 16) begin
                m_log[m_nlog] <= {m_sh[6:0], spi_mosi};
                m_nlog        <= m_nlog + 1;
            end
            m_bits <= m_bits + 1;
        end
    end

    always @(posedge spi_sck) sck_rises <= sck_rises + 1;
    always @(negedge spi_sck) spi_miso <= model_bit(m_bits, m_op, m_addr);

    // ---------------- stream collector / monitors ----------------
    logic [7:0] rx_data [64];
    logic       rx_last [64];
    int         rx_n;
    int         done_cnt;
    int         tv_cnt;

    always @(posedge clk) begin
        if (o_tvalid && tready) begin
            if (rx_n < 64) begin
                rx_data[rx_n] <= o_tdata;
                rx_last[rx_n] <= o_tlast;
            end
            rx_n <= rx_n + 1;
        end
        if (o_done)   done_cnt <= done_cnt + 1;
        if (o_tvalid) tv_cnt   <= tv_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_err;
    int n_chk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic mode, input logic [23:0] addr, input logic [15:0] len);
        @(negedge clk);
        i_start = 1'b1;
        i_mode  = mode;
        i_addr  = addr;
        i_len   = len;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        k = 0;
        while (o_done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(o_done), 32'd1);
    endtask

    logic [7:0] c_STL_EXP [8] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};

    initial begin
        int base;
        int d0;
        int s1;
        int f0;
        int t0;
        int k;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_ss",     32'(spi_ss),   32'd1);
        check("rst_sck",    32'(spi_sck),  32'd0);
        check("rst_mosi",   32'(spi_mosi), 32'd0);
        check("rst_tvalid", 32'(o_tvalid), 32'd0);
        check("rst_tdata",  32'(o_tdata),  32'd0);
        check("rst_busy",   32'(o_busy),   32'd0);
        check("rst_done",   32'(o_done),   32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // read ID
        base = rx_n;
        d0   = done_cnt;
        do_start(1'b0, 24'h0, 16'd3);
        check("id_busy", 32'(o_busy), 32'd1);
        wait_done("id_done", 2000);
        repeat (20) @(negedge clk);
        check("id_count", 32'(rx_n - base), 32'd3);
        check("id_b0", 32'(rx_data[base]),   32'hEF);
        check("id_b1", 32'(rx_data[base+1]), 32'h40);
        check("id_b2", 32'(rx_data[base+2]), 32'h18);
        check("id_tlast", 32'({rx_last[base+2], rx_last[base+1], rx_last[base]}), 32'b100);
        check("id_opcode", 32'(m_log[0]), 32'h9F);
        check("id_mosi_low_in_data", 32'(m_log[1]), 32'h00);
        check("id_ss_to_sck", 32'(first_gap), 32'(CLK_DIV));
        check("id_done_once", 32'(done_cnt - d0), 32'd1);
        check("id_ss_high", 32'(spi_ss), 32'd1);

        // read data
        base = rx_n;
        do_start(1'b1, 24'h012345, 16'd4);
        wait_done("rd_done", 3000);
        repeat (20) @(negedge clk);
        check("rd_opcode", 32'(m_log[0]), 32'(c_RD_OP));
        check("rd_a2", 32'(m_log[1]), 32'h01);
        check("rd_a1", 32'(m_log[2]), 32'h23);
        check("rd_a0", 32'(m_log[3]), 32'h45);
`ifdef SPI_FLASH_READER_FAST_READ_EN
        check("rd_dummy", 32'(m_log[4]), 32'h00);
`endif
        check("rd_count", 32'(rx_n - base), 32'd4);
        check("rd_b0", 32'(rx_data[base]),   32'hE0);
        check("rd_b1", 32'(rx_data[base+1]), 32'hE3);
        check("rd_b2", 32'(rx_data[base+2]), 32'hE2);
        check("rd_b3", 32'(rx_data[base+3]), 32'hED);
        check("rd_tlast", 32'({rx_last[base+3], rx_last[base+2], rx_last[base+1], rx_last[base]}), 32'b1000);

        // back-pressure stall after byte 2
        base = rx_n;
        do_start(1'b1, 24'h000100, 16'd8);
        k = 0;
        while ((rx_n - base) < 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        tready = 1'b0;
        repeat (50) @(negedge clk);
        s1 = sck_rises;
        check("stl_tvalid", 32'(o_tvalid), 32'd1);
        repeat (50) @(negedge clk);
        check("stl_sck_static", 32'(sck_rises - s1), 32'd0);
        check("stl_sck_low", 32'(spi_sck), 32'd0);
        check("stl_held_count", 32'(rx_n - base), 32'd2);
        tready = 1'b1;
        wait_done("stl_done", 4000);
        repeat (20) @(negedge clk);
        check("stl_count", 32'(rx_n - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("stl_data", 32'(rx_data[base+i]), 32'(c_STL_EXP[i]));
            check("stl_tlast", 32'(rx_last[base+i]), (i == 7) ? 32'd1 : 32'd0);
        end

        // zero-length request
        f0 = ss_falls;
        t0 = tv_cnt;
        @(negedge clk);
        i_start = 1'b1;
        i_mode  = 1'b0;
        i_len   = 16'd0;
        @(negedge clk);
        i_start = 1'b0;
        check("zl_done_pulse", 32'(o_done), 32'd1);
        @(negedge clk);
        check("zl_done_end", 32'(o_done), 32'd0);
        repeat (10) @(negedge clk);
        check("zl_no_ss", 32'(ss_falls - f0), 32'd0);
        check("zl_no_tvalid", 32'(tv_cnt - t0), 32'd0);
        check("zl_busy", 32'(o_busy), 32'd0);

        // reset during the second address byte
        do_start(1'b1, 24'h012345, 16'd4);
        k = 0;
        while (m_nlog < 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("ar_in_addr", 32'(o_busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("ar_ss",     32'(spi_ss),   32'd1);
        check("ar_sck",    32'(spi_sck),  32'd0);
        check("ar_mosi",   32'(spi_mosi), 32'd0);
        check("ar_busy",   32'(o_busy),   32'd0);
        check("ar_tvalid", 32'(o_tvalid), 32'd0);
        s1 = sck_rises;
        repeat (5) @(negedge clk);
        check("ar_no_edges", 32'(sck_rises - s1), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        base = rx_n;
        d0   = done_cnt;
        do_start(1'b0, 24'h0, 16'd3);
        wait_done("ar_id_done", 2000);
        repeat (20) @(negedge clk);
        check("ar_id_count", 32'(rx_n - base), 32'd3);
        check("ar_id_b0", 32'(rx_data[base]),   32'hEF);
        check("ar_id_b2", 32'(rx_data[base+2]), 32'h18);
        check("ar_id_done_once", 32'(done_cnt - d0), 32'd1);

        // start while busy is ignored
        base = rx_n;
        d0   = done_cnt;
        do_start(1'b0, 24'h0, 16'd3);
        repeat (10) @(negedge clk);
        do_start(1'b1, 24'h000200, 16'd5);
        wait_done("ib_done", 2000);
        repeat (200) @(negedge clk);
        check("ib_done_once", 32'(done_cnt - d0), 32'd1);
        check("ib_count", 32'(rx_n - base), 32'd3);
        check("ib_b2", 32'(rx_data[base+2]), 32'h18);
        check("ib_busy", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #(CLK_PERIOD * 60000);
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
